controle_corrida: RTL

//  Ride controller for the Uber simulation: accepts a ride request (origin, destination),

---
 rtl/controle_corrida.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/controle_corrida.sv
// Ride controller: accepts a ride request (origem, destino), moves the car one location per
// movement tick to the pickup point, then to the drop-off point, holds there for HOLD_TICKS
// ticks and returns to idle.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    synchronous reset, active-low
//   origem     pickup location 0..8
//   destino    drop-off location 0..8
//   solicitar  request level; a rising edge versus the previous sample is a request
//   cancelar   cancel level; only honoured while searching for the passenger
//   posicao    one-hot car position OR'd with one-hot current target while travelling
//   estado     00 LIVRE, 01 BUSCANDO, 10 EM_CORRIDA, 11 CHEGOU
//   ocupado    high whenever estado is not LIVRE
//   chegou     one-cycle pulse on entry to CHEGOU
//   erro       one-cycle pulse when a request is rejected
module controle_corrida #(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned HOLD_TICKS = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] origem,
  input  logic [3:0] destino,
  input  logic       solicitar,
  input  logic       cancelar,
  output logic [8:0] posicao,
  output logic [1:0] estado,
  output logic       ocupado,
  output logic       chegou,
  output logic       erro
);

  localparam int unsigned CntW  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HoldW = (HOLD_TICKS > 2) ? $clog2(HOLD_TICKS) : 1;

  typedef enum logic [1:0] {
    StLivre     = 2'b00,
    StBuscando  = 2'b01,
    StEmCorrida = 2'b10,
    StChegou    = 2'b11
  } estado_e;

  estado_e          estado_q, estado_d;
  logic [3:0]       carro_q, carro_d;
  logic [3:0]       origem_q, origem_d;
  logic [3:0]       destino_q, destino_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             sol_q;
  logic             chegou_d, erro_d;

  logic       tick;
  logic       req_edge;
  logic       req_valid;
  logic [3:0] alvo;
  logic [3:0] carro_step;
  logic [8:0] posicao_d;

  assign tick      = (cnt_q == CntW'(TICK_DIV - 1));
  assign req_edge  = solicitar & ~sol_q;
  assign req_valid = (origem <= 4'd8) && (destino <= 4'd8) && (origem != destino);

  // Target is only meaningful while travelling; elsewhere the step result is unused.
  assign alvo = (estado_q == StEmCorrida) ? destino_q : origem_q;

  always_comb begin
    carro_step = carro_q;
    if (carro_q < alvo) begin
      carro_step = carro_q + 4'd1;
    end else if (carro_q > alvo) begin
      carro_step = carro_q - 4'd1;
    end
  end

  always_comb begin
    estado_d  = estado_q;
    carro_d   = carro_q;
    origem_d  = origem_q;
    destino_d = destino_q;
    hold_d    = hold_q;
    cnt_d     = tick ? '0 : cnt_q + CntW'(1);
    chegou_d  = 1'b0;
    erro_d    = 1'b0;

    unique case (estado_q)
      StLivre: begin
        if (req_edge) begin
          origem_d  = origem;
          destino_d = destino;
          if (!req_valid) begin
            erro_d = 1'b1;
          end else begin
            // Restart the tick phase so the first step lands TICK_DIV cycles later.
            cnt_d    = '0;
            estado_d = (carro_q == origem) ? StEmCorrida : StBuscando;
          end
        end
      end
      StBuscando: begin
        // Cancel wins over arrival; arrival is checked before any movement.
        if (cancelar) begin
          estado_d = StLivre;
        end else if (carro_q == origem_q) begin
          estado_d = StEmCorrida;
        end else if (tick) begin
          carro_d = carro_step;
        end
      end
      StEmCorrida: begin
        if (carro_q == destino_q) begin
          estado_d = StChegou;
          chegou_d = 1'b1;
          hold_d   = '0;
        end else if (tick) begin
          carro_d = carro_step;
        end
      end
      StChegou: begin
        if (tick) begin
          if (hold_q == HoldW'(HOLD_TICKS - 1)) begin
            estado_d = StLivre;
          end else begin
            hold_d = hold_q + HoldW'(1);
          end
        end
      end
      default: estado_d = StLivre;
    endcase
  end

  // Outputs are registered from next-state values so they line up with estado.
  always_comb begin
    posicao_d = 9'(1) << carro_d;
    if (estado_d == StBuscando) begin
      posicao_d = posicao_d | (9'(1) << origem_d);
    end else if (estado_d == StEmCorrida) begin
      posicao_d = posicao_d | (9'(1) << destino_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      estado_q  <= StLivre;
      carro_q   <= '0;
      origem_q  <= '0;
      destino_q <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
      sol_q     <= 1'b0;
      posicao   <= 9'b000000001;
      ocupado   <= 1'b0;
      chegou    <= 1'b0;
      erro      <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      carro_q   <= carro_d;
      origem_q  <= origem_d;
      destino_q <= destino_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      sol_q     <= solicitar;
      posicao   <= posicao_d;
      ocupado   <= (estado_d != StLivre);
      chegou    <= chegou_d;
      erro      <= erro_d;
    end
  end

  assign estado = estado_q;

endmodule
